// File: rtl/lsab_cwp_pkg.sv
// rtl/lsab_cwp_pkg.sv - shared parameters and types for the lsab_cwp channelised FIFO
package lsab_cwp_pkg;
`include "lsab_defs.v"

   localparam int DEF_WIDTH    = `LSAB_DEF_WIDTH;
   localparam int DEF_DEPTH    = `LSAB_DEF_DEPTH;
   localparam int DEF_CHANNELS = `LSAB_DEF_CHANNELS;

endpackage

// File: rtl/lsab_cwp_chan.sv
// rtl/lsab_cwp_chan.sv - per-channel pointers, occupancy, status and sticky error flags
module lsab_cwp_chan
   import lsab_cwp_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int BFULL_LVL = DEPTH - 2,
   parameter int LW        = lsab_log2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic          err_clr,
   output logic          push_ok,
   output logic          pop_ok,
   output logic [LW-2:0] wptr,
   output logic [LW-2:0] rptr,
   output logic [LW-1:0] level,
   output logic          bfull,
   output logic          empty,
   output logic          overflow,
   output logic          underflow
);
   localparam int PW = LW - 1;
   localparam logic [LW-1:0] FULL_CNT  = LW'(DEPTH);
   localparam logic [LW-1:0] BFULL_CNT = LW'(BFULL_LVL);

   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0] count_q, count_d;
   logic          bfull_q, bfull_d, empty_q, empty_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;

   always_comb begin
      pop_ok  = pop && !flush && (count_q != '0);
      // A full channel still accepts a push when the same edge frees a slot.
      push_ok = push && !flush && ((count_q != FULL_CNT) || pop_ok);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + PW'(1);
         if (pop_ok)  rptr_d = rptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
         endcase
      end
      bfull_d = (count_d >= BFULL_CNT);
      empty_d = (count_d == '0);
      ovf_d   = (ovf_q && !err_clr) || (push && !flush && !push_ok);
      unf_d   = (unf_q && !err_clr) || (pop && !flush && (count_q == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         bfull_q <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         bfull_q <= bfull_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign wptr      = wptr_q;
   assign rptr      = rptr_q;
   assign level     = count_q;
   assign bfull     = bfull_q;
   assign empty     = empty_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: rtl/lsab_defs.v
// rtl/lsab_defs.v - default lsab_cwp dimensions and the log2 helper
`ifndef LSAB_DEFS_V
`define LSAB_DEFS_V

`define LSAB_DEF_WIDTH    32
`define LSAB_DEF_DEPTH    16
`define LSAB_DEF_CHANNELS 4

// Ceiling log2: number of address bits needed to index v entries.
function automatic int lsab_log2(input int v);
   int r;
   r = 0;
   while ((1 << r) < v) r++;
   return r;
endfunction

`endif

// File: rtl/lsab_cwp.sv
// rtl/lsab_cwp.sv - multi-channel FIFO sharing one storage array addressed {channel, pointer}
module lsab_cwp
   import lsab_cwp_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int BFULL_LVL = DEPTH - 2,
   localparam int CW       = lsab_log2(CHANNELS),
   localparam int LW       = lsab_log2(DEPTH) + 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      WRITE,
   input  logic [CW-1:0]             WRITE_FIFO,
   input  logic [WIDTH-1:0]          IN,
   input  logic                      READ,
   input  logic [CW-1:0]             READ_FIFO,
   input  logic [CHANNELS-1:0]       FLUSH,
   input  logic                      ERR_CLR,
   output logic [CHANNELS*WIDTH-1:0] OUT,
   output logic [CHANNELS-1:0]       BFULL,
   output logic [CHANNELS-1:0]       EMPTY,
   output logic [CHANNELS*LW-1:0]    LEVEL,
   output logic [CHANNELS-1:0]       OVERFLOW,
   output logic [CHANNELS-1:0]       UNDERFLOW
);
   localparam int PW = LW - 1;

   logic [CHANNELS-1:0]          push_ok, pop_ok;
   logic [CHANNELS-1:0][PW-1:0]  wptr, rptr;
   logic [WIDTH-1:0]             mem [CHANNELS*DEPTH];
   logic [CW+PW-1:0]             waddr, raddr;
   logic [WIDTH-1:0]             head;
   logic [CHANNELS*WIDTH-1:0]    out_q, out_d;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      lsab_cwp_chan #(
         .DEPTH     (DEPTH),
         .BFULL_LVL (BFULL_LVL),
         .LW        (LW)
      ) u_chan (
         .clk       (CLK),
         .rst       (RST),
         .push      (WRITE && (WRITE_FIFO == CW'(c))),
         .pop       (READ && (READ_FIFO == CW'(c))),
         .flush     (FLUSH[c]),
         .err_clr   (ERR_CLR),
         .push_ok   (push_ok[c]),
         .pop_ok    (pop_ok[c]),
         .wptr      (wptr[c]),
         .rptr      (rptr[c]),
         .level     (LEVEL[c*LW +: LW]),
         .bfull     (BFULL[c]),
         .empty     (EMPTY[c]),
         .overflow  (OVERFLOW[c]),
         .underflow (UNDERFLOW[c])
      );
   end

   assign waddr = {WRITE_FIFO, wptr[WRITE_FIFO]};
   assign raddr = {READ_FIFO, rptr[READ_FIFO]};
   // Head is read before the edge, so a push+pop on a full channel returns the old word.
   assign head  = mem[raddr];

   always_ff @(posedge CLK) begin
      if (|push_ok) mem[waddr] <= IN;
   end

   always_comb begin
      out_d = out_q;
      if (|pop_ok) out_d[READ_FIFO*WIDTH +: WIDTH] = head;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) out_q <= '0;
      else     out_q <= out_d;
   end

   assign OUT = out_q;

endmodule

// File: tb/tb_lsab_cwp.sv
// tb/tb_lsab_cwp.sv - self-checking bench for lsab_cwp with a queue-based reference model
module tb_lsab_cwp;
   localparam int W  = 32;
   localparam int D  = 16;
   localparam int C  = 4;
   localparam int LW = 5;
   localparam int BL = D - 2;

   logic           CLK = 1'b0;
   logic           RST;
   logic           WRITE, READ, ERR_CLR;
   logic [1:0]     WRITE_FIFO, READ_FIFO;
   logic [W-1:0]   IN;
   logic [C-1:0]   FLUSH;
   logic [C*W-1:0] OUT;
   logic [C-1:0]   BFULL, EMPTY, OVERFLOW, UNDERFLOW;
   logic [C*LW-1:0] LEVEL;

   int n_chk  = 0;
   int n_pass = 0;

   lsab_cwp dut (
      .CLK(CLK), .RST(RST), .WRITE(WRITE), .WRITE_FIFO(WRITE_FIFO), .IN(IN),
      .READ(READ), .READ_FIFO(READ_FIFO), .FLUSH(FLUSH), .ERR_CLR(ERR_CLR),
      .OUT(OUT), .BFULL(BFULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   // Reference model: one queue per channel, last popped word, sticky flags.
   logic [W-1:0] mq [C][$];
   logic [W-1:0] m_out [C];
   logic [C-1:0] m_ovf, m_unf;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int c = 0; c < C; c++) begin
            mq[c].delete();
            m_out[c] <= '0;
         end
         m_ovf <= '0;
         m_unf <= '0;
      end else begin
         if (ERR_CLR) begin
            m_ovf <= '0;
            m_unf <= '0;
         end
         for (int c = 0; c < C; c++) begin
            if (FLUSH[c]) begin
               mq[c].delete();
            end else begin
               if (READ && READ_FIFO == 2'(c)) begin
                  if (mq[c].size() > 0) m_out[c] <= mq[c].pop_front();
                  else                  m_unf[c] <= 1'b1;
               end
               if (WRITE && WRITE_FIFO == 2'(c)) begin
                  if (mq[c].size() < D) mq[c].push_back(IN);
                  else                  m_ovf[c] <= 1'b1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge CLK) begin
      logic [C*W-1:0]  e_out;
      logic [C*LW-1:0] e_lvl;
      logic [C-1:0]    e_emp, e_bf;
      for (int c = 0; c < C; c++) begin
         e_out[c*W +: W]   = m_out[c];
         e_lvl[c*LW +: LW] = LW'(mq[c].size());
         e_emp[c]          = (mq[c].size() == 0);
         e_bf[c]           = (mq[c].size() >= BL);
      end
      check("model_out", OUT, e_out);
      check("model_level", LEVEL, e_lvl);
      check("model_empty", EMPTY, e_emp);
      check("model_bfull", BFULL, e_bf);
      check("model_overflow", OVERFLOW, m_ovf);
      check("model_underflow", UNDERFLOW, m_unf);
   end

   function automatic logic [W-1:0] out_of(input int c);
      return OUT[c*W +: W];
   endfunction

   function automatic logic [LW-1:0] lvl(input int c);
      return LEVEL[c*LW +: LW];
   endfunction

   // Drive one edge's worth of inputs from a negedge, return at the next negedge.
   task automatic cyc(input logic w, input int wf, input int d, input logic r, input int rf,
                      input logic [C-1:0] fl, input logic ec);
      WRITE = w; WRITE_FIFO = 2'(wf); IN = W'(d);
      READ = r; READ_FIFO = 2'(rf); FLUSH = fl; ERR_CLR = ec;
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1;
      WRITE = 0; WRITE_FIFO = 0; IN = 0; READ = 0; READ_FIFO = 0; FLUSH = 0; ERR_CLR = 0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_level", LEVEL, 0);
      check("rst_empty", EMPTY, 4'hF);
      check("rst_out", OUT, 0);
      check("rst_bfull", BFULL, 0);
      RST = 1'b0;

      for (int i = 0; i < 16; i++) cyc(1, 2, i, 0, 0, 0, 0);
      check("ch2_level_full", lvl(2), 16);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 0, 1, 2, 0, 0);
         check("ch2_pop_order", out_of(2), i);
      end
      check("ch2_empty_end", EMPTY[2], 1);

      for (int i = 0; i < 14; i++) begin
         cyc(1, 1, 200 + i, 0, 0, 0, 0);
         if (i == 12) check("ch1_bfull_at_13", BFULL[1], 0);
      end
      check("ch1_bfull_at_14", BFULL[1], 1);
      check("ch1_level_14", lvl(1), 14);
      cyc(0, 0, 0, 1, 1, 0, 0);
      check("ch1_bfull_after_pop", BFULL[1], 0);
      check("ch1_pop_head", out_of(1), 200);

      cyc(0, 0, 0, 0, 0, 4'b0010, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 300 + i, 0, 0, 0, 0);
      check("ch1_level_5", lvl(1), 5);
      cyc(1, 1, 999, 0, 0, 4'b0010, 0);
      check("flush_level", lvl(1), 0);
      check("flush_empty", EMPTY[1], 1);
      check("flush_no_ovf", OVERFLOW[1], 0);

      for (int i = 0; i < 16; i++) cyc(1, 0, 100 + i, 0, 0, 0, 0);
      check("ch0_level_full", lvl(0), 16);
      cyc(1, 0, 555, 0, 0, 0, 0);
      check("ch0_overflow", OVERFLOW[0], 1);
      check("ch0_level_after_drop", lvl(0), 16);
      cyc(1, 0, 556, 1, 0, 0, 0);
      check("ch0_full_pushpop_level", lvl(0), 16);
      check("ch0_full_pushpop_out", out_of(0), 100);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("ovf_cleared", OVERFLOW, 0);

      cyc(0, 0, 0, 1, 3, 0, 0);
      check("ch3_out_held", out_of(3), 0);
      check("ch3_underflow", UNDERFLOW[3], 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("unf_cleared", UNDERFLOW, 0);
      cyc(0, 0, 0, 1, 3, 0, 1);
      check("err_wins_over_clr", UNDERFLOW[3], 1);
      cyc(1, 3, 77, 1, 3, 0, 0);
      check("empty_pushpop_level", lvl(3), 1);
      check("empty_pushpop_no_bypass", out_of(3), 0);
      cyc(1, 2, 42, 1, 3, 0, 1);
      check("xchan_out3", out_of(3), 77);
      check("xchan_level2", lvl(2), 1);

      cyc(0, 0, 0, 0, 0, 4'b0001, 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 600 + i, 0, 0, 0, 0);
      check("ch0_level_7", lvl(0), 7);
      #3 RST = 1'b1;
      #1;
      check("midrst_level", LEVEL, 0);
      check("midrst_empty", EMPTY, 4'hF);
      check("midrst_out", OUT, 0);
      check("midrst_flags", {OVERFLOW, UNDERFLOW, BFULL}, 0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i <= 40; i++) begin
         cyc(i < 40, 0, 700 + i, i > 0, 0, 0, 0);
         if (i > 0) check("wrap_order", out_of(0), 700 + i - 1);
      end
      check("wrap_empty_end", EMPTY[0], 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
